// File: rtl/seg7_pkg.sv
// Shared segment patterns and BCD-to-segment lookup for the 4-digit scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Non-BCD codes show a dash so a corrupted time word is visible on the display.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Time-bus and display-pin bundle of the scan driver.
// master = stopwatch/board side, slave = the scan driver itself.
interface seg7_scan_driver_if;

    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic        dp_blink;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    modport master (
        output bcd_in, load, blank_lz, dp_mask, dp_blink,
        input  an, seg, dp, frame
    );

    modport slave (
        input  bcd_in, load, blank_lz, dp_mask, dp_blink,
        output an, seg, dp, frame
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit decoder: BCD nibble to active-low segments, with a
// blank override used for leading-zero suppression.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    assign o_seg = i_blank ? SEG_OFF : bcd_to_seg(i_bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: shadow/display BCD registers,
// slot prescaler with anti-ghost blanking, leading-zero suppression and blinking dp.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic               clk,
    input  logic               reset,
    seg7_scan_driver_if.slave  bus
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [15:0]   r_disp;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame;

    logic          w_tick;
    logic          w_frame_tick;
    logic          w_blink_wrap;
    logic          w_blank_slot;
    logic [3:0]    w_digit;
    logic          w_lz_blank;
    logic          w_dp_on;
    logic [6:0]    w_seg;

    assign w_tick       = (r_presc == PW'(SCAN_DIV - 1));
    assign w_frame_tick = w_tick && (r_idx == 2'd3);
    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));
    assign w_blank_slot = (r_presc < PW'(BLANK_CYC));
    assign w_digit      = r_disp[{r_idx, 2'b00} +: 4];
    assign w_dp_on      = bus.dp_mask[r_idx] && (!bus.dp_blink || r_phase);

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd3:    w_lz_blank = (r_disp[15:12] == 4'h0);
            2'd2:    w_lz_blank = (r_disp[15:8]  == 8'h00);
            2'd1:    w_lz_blank = (r_disp[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
        w_lz_blank = w_lz_blank && bus.blank_lz;
    end

    seg7_decode u_decode (
        .i_bcd   (w_digit),
        .i_blank (w_lz_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc     <= '0;
            r_idx       <= 2'd0;
            r_shadow    <= 16'h0000;
            r_disp      <= 16'h0000;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_idx <= r_idx + 2'd1;
            if (bus.load)
                r_shadow <= bus.bcd_in;
            // Takes the shadow as it stood before this edge, so a coincident load waits a frame.
            if (w_frame_tick)
                r_disp <= r_shadow;
            if (w_tick) begin
                if (w_blink_wrap) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an    <= 4'hF;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_frame_tick;
            if (w_blank_slot) begin
                r_an  <= 4'hF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_seg;
                r_dp  <= ~w_dp_on;
            end
        end
    end

    assign bus.an    = r_an;
    assign bus.seg   = r_seg;
    assign bus.dp    = r_dp;
    assign bus.frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-indexed reference model queues the
// expected pins for every clock, a negedge monitor pops and compares.
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BD = 2;
    localparam int FR = 4 * SD;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    logic clk;
    logic reset;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC),
        .BLINK_DIV (BD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    logic [15:0] shadow_m = 16'h0000;
    logic [15:0] disp_m = 16'h0000;
    logic [6:0]  tab [10];

    initial begin
        tab[0] = 7'h40; tab[1] = 7'h79; tab[2] = 7'h24; tab[3] = 7'h30; tab[4] = 7'h19;
        tab[5] = 7'h12; tab[6] = 7'h02; tab[7] = 7'h78; tab[8] = 7'h00; tab[9] = 7'h10;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Edge n (1-based since reset release) shows the state held during clock n-1:
    // prescaler (n-1)%SD, slot (n-1)/SD, digit slot%4, blink phase (slot/BD)%2.
    task automatic step();
        exp_t        e;
        int          p, slot, idx, ph;
        logic [15:0] upper;
        logic [3:0]  dig;
        @(posedge clk);
        n++;
        p    = (n - 1) % SD;
        slot = (n - 1) / SD;
        idx  = slot % 4;
        ph   = (slot / BD) % 2;
        e.n     = n;
        e.frame = (n % FR == 0);
        if (p < BC) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an  = 4'hF ^ 4'(1 << idx);
            upper = disp_m >> (4 * idx);
            dig   = upper[3:0];
            if (bus.blank_lz && idx > 0 && upper == 16'h0000)
                e.seg = 7'h7F;
            else if (dig > 4'd9)
                e.seg = 7'h3F;
            else
                e.seg = tab[dig];
            e.dp = !(bus.dp_mask[idx] && (!bus.dp_blink || ph == 1));
        end
        q.push_back(e);
        if (n % FR == 0)
            disp_m = shadow_m;
        if (bus.load)
            shadow_m = bus.bcd_in;
        #1;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.bcd_in = v;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({bus.an, bus.seg, bus.dp, bus.frame} !== {e.an, e.seg, e.dp, e.frame}) begin
                errors++;
                $display("FAIL scan n=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b",
                         e.n, bus.an, bus.seg, bus.dp, bus.frame, e.an, e.seg, e.dp, e.frame);
            end
        end
    end

    task automatic release_reset();
        @(negedge clk);
        reset    = 1'b0;
        n        = 0;
        shadow_m = 16'h0000;
        disp_m   = 16'h0000;
    endtask

    initial begin
        reset        = 1'b1;
        bus.bcd_in   = 16'h0000;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 4'b0000;
        bus.dp_blink = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset an", int'(bus.an), 'hF);
        chk("reset seg", int'(bus.seg), 'h7F);
        chk("reset dp", int'(bus.dp), 1);
        chk("reset frame", int'(bus.frame), 0);
        release_reset();

        // First frame pulse and a full frame of zeros, then 5959 unsuppressed.
        run(FR + 2);
        do_load(16'h5959);
        run(2 * FR);

        // Mid-slot asynchronous reset: outputs must drop before the next edge.
        run(3 * SD / 2 + 1);
        #2 reset = 1'b1;
        #1;
        chk("midreset an", int'(bus.an), 'hF);
        chk("midreset seg", int'(bus.seg), 'h7F);
        chk("midreset dp", int'(bus.dp), 1);
        chk("midreset frame", int'(bus.frame), 0);
        q.delete();
        repeat (2) @(posedge clk);
        release_reset();

        do_load(16'h5959);
        run(2 * FR);

        bus.blank_lz = 1'b1;
        do_load(16'h0007);
        run(2 * FR);
        bus.blank_lz = 1'b0;
        run(FR);

        bus.blank_lz = 1'b1;
        do_load(16'h1A0F);
        run(2 * FR);
        do_load(16'h0000);
        run(FR);

        // Load lands on the frame edge: this frame keeps the old shadow.
        while ((n + 1) % FR != 0) step();
        do_load(16'h1234);
        run(2 * FR);

        bus.dp_mask  = 4'b0100;
        bus.dp_blink = 1'b1;
        run(4 * FR);
        bus.dp_blink = 1'b0;
        run(2 * FR);

        for (int i = 0; i < 480; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.bcd_in = 16'($urandom) >> (4 * $urandom_range(0, 3));
                bus.load   = 1'b1;
            end else begin
                bus.load   = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) bus.blank_lz = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.dp_mask  = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.dp_blink = 1'($urandom);
            step();
        end
        bus.load = 1'b0;

        @(negedge clk);
        #1;
        chk("queue drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
